// File: rtl/mips_multicycle_ctrl_pkg.sv
// Shared definitions for the multicycle MIPS controller: state and instruction classes,
// opcode/funct constants, ULA operation codes and the control-word payload.
package mips_multicycle_ctrl_pkg;

  localparam int unsigned OP_W     = 6;
  localparam int unsigned FUNCT_W  = 6;
  localparam int unsigned ULA_OP_W = 4;
  localparam int unsigned PC_SRC_W = 2;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_HALT   = 3'd5
  } state_e;

  typedef enum logic [2:0] {
    CLS_RTYPE = 3'd0,
    CLS_ADDI  = 3'd1,
    CLS_LW    = 3'd2,
    CLS_SW    = 3'd3,
    CLS_BEQ   = 3'd4,
    CLS_J     = 3'd5,
    CLS_NONE  = 3'd6
  } instr_cls_e;

  localparam logic [OP_W-1:0] OP_RTYPE = 6'h00;
  localparam logic [OP_W-1:0] OP_J     = 6'h02;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'h04;
  localparam logic [OP_W-1:0] OP_ADDI  = 6'h08;
  localparam logic [OP_W-1:0] OP_LW    = 6'h23;
  localparam logic [OP_W-1:0] OP_SW    = 6'h2B;

  localparam logic [FUNCT_W-1:0] FN_ADD = 6'h20;
  localparam logic [FUNCT_W-1:0] FN_SUB = 6'h22;
  localparam logic [FUNCT_W-1:0] FN_AND = 6'h24;
  localparam logic [FUNCT_W-1:0] FN_OR  = 6'h25;
  localparam logic [FUNCT_W-1:0] FN_SLT = 6'h2A;

  localparam logic [ULA_OP_W-1:0] ULA_AND = 4'd0;
  localparam logic [ULA_OP_W-1:0] ULA_OR  = 4'd1;
  localparam logic [ULA_OP_W-1:0] ULA_ADD = 4'd2;
  localparam logic [ULA_OP_W-1:0] ULA_SUB = 4'd6;
  localparam logic [ULA_OP_W-1:0] ULA_SLT = 4'd7;

  localparam logic [PC_SRC_W-1:0] PC_SRC_SEQ    = 2'd0;
  localparam logic [PC_SRC_W-1:0] PC_SRC_BRANCH = 2'd1;
  localparam logic [PC_SRC_W-1:0] PC_SRC_JUMP   = 2'd2;

  typedef struct packed {
    logic                pc_write;
    logic [PC_SRC_W-1:0] pc_src;
    logic                ir_write;
    logic                imem_req;
    logic                dmem_read;
    logic                dmem_write;
    logic                reg_write;
    logic                reg_dst;
    logic                mem_to_reg;
    logic                ula_src_b;
    logic [ULA_OP_W-1:0] ula_op;
    logic                illegal;
  } ctrl_t;

  // Instructions whose second ULA operand is the sign-extended immediate.
  function automatic logic uses_imm(input instr_cls_e cls);
    return (cls == CLS_ADDI) || (cls == CLS_LW) || (cls == CLS_SW);
  endfunction

endpackage

// File: rtl/mips_multicycle_ctrl_if.sv
// Control/status bundle between the multicycle controller (master) and the datapath (slave).
interface mips_multicycle_ctrl_if #(
  parameter int unsigned CNT_W = 32
);
  import mips_multicycle_ctrl_pkg::*;

  logic [OP_W-1:0]     opcode;
  logic [FUNCT_W-1:0]  funct;
  logic                zero_flag;
  logic                imem_ready;
  logic                dmem_ready;

  logic                pc_write;
  logic [PC_SRC_W-1:0] pc_src;
  logic                ir_write;
  logic                imem_req;
  logic                dmem_read;
  logic                dmem_write;
  logic                reg_write;
  logic                reg_dst;
  logic                mem_to_reg;
  logic                ula_src_b;
  logic [ULA_OP_W-1:0] ula_op;
  logic                illegal;
  logic                bus_err;
  logic [CNT_W-1:0]    instr_count;

  modport master (
    input  opcode, funct, zero_flag, imem_ready, dmem_ready,
    output pc_write, pc_src, ir_write, imem_req, dmem_read, dmem_write,
           reg_write, reg_dst, mem_to_reg, ula_src_b, ula_op, illegal,
           bus_err, instr_count
  );

  modport slave (
    output opcode, funct, zero_flag, imem_ready, dmem_ready,
    input  pc_write, pc_src, ir_write, imem_req, dmem_read, dmem_write,
           reg_write, reg_dst, mem_to_reg, ula_src_b, ula_op, illegal,
           bus_err, instr_count
  );
endinterface

// File: rtl/mips_multicycle_ctrl_ula_decode.sv
// Combinational classifier: (opcode, funct) -> instruction class, ULA operation, illegal flag.
module mips_ula_decode
  import mips_multicycle_ctrl_pkg::*;
(
  input  logic [OP_W-1:0]     opcode_i,
  input  logic [FUNCT_W-1:0]  funct_i,
  output logic [ULA_OP_W-1:0] ula_op_o,
  output instr_cls_e          cls_o,
  output logic                illegal_o
);

  always_comb begin
    ula_op_o  = ULA_AND;
    cls_o     = CLS_NONE;
    illegal_o = 1'b1;
    case (opcode_i)
      OP_RTYPE: begin
        illegal_o = 1'b0;
        cls_o     = CLS_RTYPE;
        case (funct_i)
          FN_ADD:  ula_op_o = ULA_ADD;
          FN_SUB:  ula_op_o = ULA_SUB;
          FN_AND:  ula_op_o = ULA_AND;
          FN_OR:   ula_op_o = ULA_OR;
          FN_SLT:  ula_op_o = ULA_SLT;
          default: begin
            illegal_o = 1'b1;
            cls_o     = CLS_NONE;
          end
        endcase
      end
      OP_ADDI: begin illegal_o = 1'b0; cls_o = CLS_ADDI; ula_op_o = ULA_ADD; end
      OP_LW:   begin illegal_o = 1'b0; cls_o = CLS_LW;   ula_op_o = ULA_ADD; end
      OP_SW:   begin illegal_o = 1'b0; cls_o = CLS_SW;   ula_op_o = ULA_ADD; end
      OP_BEQ:  begin illegal_o = 1'b0; cls_o = CLS_BEQ;  ula_op_o = ULA_SUB; end
      OP_J:    begin illegal_o = 1'b0; cls_o = CLS_J;    ula_op_o = ULA_AND; end
      default: ;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS control FSM: sequences FETCH/DECODE/EXEC/MEM/WB, times out stalled
// memory handshakes into HALT, and counts retired instructions.
module mips_multicycle_ctrl
  import mips_multicycle_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W       = 32,
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic                   clock,
  input  logic                   reset,
  mips_multicycle_ctrl_if.master bus
);

  localparam int unsigned WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

  state_e              state_q;
  logic [WAIT_W-1:0]   wait_q;
  logic [CNT_W-1:0]    count_q;
  logic                bus_err_q;

  logic [ULA_OP_W-1:0] dec_ula_op;
  instr_cls_e          dec_cls;
  logic                dec_illegal;
  ctrl_t               ctrl_c;

  // The IR is held from DECODE onward, so the live opcode/funct identify the instruction.
  mips_ula_decode u_ula_decode (
    .opcode_i  (bus.opcode),
    .funct_i   (bus.funct),
    .ula_op_o  (dec_ula_op),
    .cls_o     (dec_cls),
    .illegal_o (dec_illegal)
  );

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q   <= ST_FETCH;
      wait_q    <= '0;
      count_q   <= '0;
      bus_err_q <= 1'b0;
    end else begin
      case (state_q)
        ST_FETCH: begin
          if (bus.imem_ready) begin
            state_q <= ST_DECODE;
            wait_q  <= '0;
          end else if (wait_q == WAIT_LAST) begin
            state_q   <= ST_HALT;
            wait_q    <= '0;
            bus_err_q <= 1'b1;
          end else begin
            wait_q <= wait_q + WAIT_W'(1);
          end
        end
        ST_DECODE: state_q <= dec_illegal ? ST_FETCH : ST_EXEC;
        ST_EXEC: begin
          case (dec_cls)
            CLS_BEQ, CLS_J: begin
              state_q <= ST_FETCH;
              count_q <= count_q + CNT_W'(1);
            end
            CLS_LW, CLS_SW: state_q <= ST_MEM;
            default:        state_q <= ST_WB;
          endcase
        end
        ST_MEM: begin
          if (bus.dmem_ready) begin
            wait_q <= '0;
            if (dec_cls == CLS_LW) begin
              state_q <= ST_WB;
            end else begin
              state_q <= ST_FETCH;
              count_q <= count_q + CNT_W'(1);
            end
          end else if (wait_q == WAIT_LAST) begin
            state_q   <= ST_HALT;
            wait_q    <= '0;
            bus_err_q <= 1'b1;
          end else begin
            wait_q <= wait_q + WAIT_W'(1);
          end
        end
        ST_WB: begin
          state_q <= ST_FETCH;
          count_q <= count_q + CNT_W'(1);
        end
        ST_HALT: state_q <= ST_HALT;
        default: state_q <= ST_FETCH;
      endcase
    end
  end

  // Control word decoded from the current state; forced low while reset is asserted.
  always_comb begin
    ctrl_c = '0;
    if (reset) begin
      case (state_q)
        ST_FETCH: begin
          ctrl_c.imem_req = 1'b1;
          if (bus.imem_ready) begin
            ctrl_c.ir_write = 1'b1;
            ctrl_c.pc_write = 1'b1;
            ctrl_c.pc_src   = PC_SRC_SEQ;
          end
        end
        ST_DECODE: ctrl_c.illegal = dec_illegal;
        ST_EXEC: begin
          ctrl_c.ula_op    = dec_ula_op;
          ctrl_c.ula_src_b = uses_imm(dec_cls);
          if (dec_cls == CLS_BEQ && bus.zero_flag) begin
            ctrl_c.pc_write = 1'b1;
            ctrl_c.pc_src   = PC_SRC_BRANCH;
          end
          if (dec_cls == CLS_J) begin
            ctrl_c.pc_write = 1'b1;
            ctrl_c.pc_src   = PC_SRC_JUMP;
          end
        end
        ST_MEM: begin
          ctrl_c.ula_op     = dec_ula_op;
          ctrl_c.ula_src_b  = 1'b1;
          ctrl_c.dmem_read  = (dec_cls == CLS_LW);
          ctrl_c.dmem_write = (dec_cls == CLS_SW);
        end
        ST_WB: begin
          ctrl_c.ula_op     = dec_ula_op;
          ctrl_c.ula_src_b  = uses_imm(dec_cls);
          ctrl_c.reg_write  = 1'b1;
          ctrl_c.reg_dst    = (dec_cls == CLS_RTYPE);
          ctrl_c.mem_to_reg = (dec_cls == CLS_LW);
        end
        default: ;
      endcase
    end
  end

  assign bus.pc_write    = ctrl_c.pc_write;
  assign bus.pc_src      = ctrl_c.pc_src;
  assign bus.ir_write    = ctrl_c.ir_write;
  assign bus.imem_req    = ctrl_c.imem_req;
  assign bus.dmem_read   = ctrl_c.dmem_read;
  assign bus.dmem_write  = ctrl_c.dmem_write;
  assign bus.reg_write   = ctrl_c.reg_write;
  assign bus.reg_dst     = ctrl_c.reg_dst;
  assign bus.mem_to_reg  = ctrl_c.mem_to_reg;
  assign bus.ula_src_b   = ctrl_c.ula_src_b;
  assign bus.ula_op      = ctrl_c.ula_op;
  assign bus.illegal     = ctrl_c.illegal;
  assign bus.bus_err     = bus_err_q;
  assign bus.instr_count = count_q;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Directed bench for mips_multicycle_ctrl: per-cycle control words for each instruction
// class, memory wait states, illegal decode, reset mid-access and handshake timeout.
module tb_mips_multicycle_ctrl;
  import mips_multicycle_ctrl_pkg::*;

  localparam int unsigned CNT_W = 32;

  // Control-word bit masks: {pc_write, pc_src[1:0], ir_write, imem_req, dmem_read, dmem_write,
  // reg_write, reg_dst, mem_to_reg, ula_src_b, ula_op[3:0], illegal}
  localparam logic [15:0] M_PCW    = 16'h8000;
  localparam logic [15:0] M_SRC_BR = 16'h2000;
  localparam logic [15:0] M_SRC_J  = 16'h4000;
  localparam logic [15:0] M_IRW    = 16'h1000;
  localparam logic [15:0] M_IMREQ  = 16'h0800;
  localparam logic [15:0] M_DRD    = 16'h0400;
  localparam logic [15:0] M_DWR    = 16'h0200;
  localparam logic [15:0] M_RW     = 16'h0100;
  localparam logic [15:0] M_RDST   = 16'h0080;
  localparam logic [15:0] M_M2R    = 16'h0040;
  localparam logic [15:0] M_SRCB   = 16'h0020;
  localparam logic [15:0] M_ILL    = 16'h0001;
  localparam logic [15:0] M_FETCH  = M_PCW | M_IRW | M_IMREQ;

  logic clock = 1'b0;
  logic reset;
  int   n_cmp   = 0;
  int   n_err   = 0;
  int   exp_cnt = 0;

  always #5 clock = ~clock;

  mips_multicycle_ctrl_if #(.CNT_W(CNT_W)) ifc ();

  mips_multicycle_ctrl #(.CNT_W(CNT_W), .MEM_TIMEOUT(15)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (ifc)
  );

  function automatic logic [15:0] ctrl_vec();
    return {ifc.pc_write, ifc.pc_src, ifc.ir_write, ifc.imem_req, ifc.dmem_read,
            ifc.dmem_write, ifc.reg_write, ifc.reg_dst, ifc.mem_to_reg, ifc.ula_src_b,
            ifc.ula_op, ifc.illegal};
  endfunction

  function automatic logic [15:0] ula_f(input logic [3:0] u);
    return {11'd0, u, 1'b0};
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Zero-wait FETCH then DECODE; returns one step into the following state.
  task automatic fetch_decode(input string tag, input logic [5:0] op, input logic [5:0] fn,
                              input logic exp_ill);
    ifc.opcode = op; ifc.funct = fn; ifc.imem_ready = 1'b1;
    ifc.dmem_ready = 1'b0; ifc.zero_flag = 1'b0;
    #1 check_eq({tag, ".fetch"}, 32'(ctrl_vec()), 32'(M_FETCH));
    tick();
    ifc.imem_ready = 1'b0;
    #1 check_eq({tag, ".decode"}, 32'(ctrl_vec()), exp_ill ? 32'(M_ILL) : 32'd0);
    tick();
  endtask

  task automatic check_retired(input string tag);
    #1 check_eq({tag, ".count"}, ifc.instr_count, 32'(exp_cnt));
    check_eq({tag, ".refetch"}, 32'(ifc.imem_req), 32'd1);
  endtask

  task automatic run_rtype(input string tag, input logic [5:0] fn, input logic [3:0] uop);
    fetch_decode(tag, OP_RTYPE, fn, 1'b0);
    #1 check_eq({tag, ".exec"}, 32'(ctrl_vec()), 32'(ula_f(uop)));
    tick();
    #1 check_eq({tag, ".wb"}, 32'(ctrl_vec()), 32'(M_RW | M_RDST | ula_f(uop)));
    tick();
    exp_cnt++;
    check_retired(tag);
  endtask

  initial begin
    reset = 1'b0;
    ifc.opcode = '0; ifc.funct = '0; ifc.zero_flag = 1'b0;
    ifc.imem_ready = 1'b0; ifc.dmem_ready = 1'b0;
    tick(); tick();
    #1 check_eq("rst.ctrl", 32'(ctrl_vec()), 32'd0);
    check_eq("rst.count", ifc.instr_count, 32'd0);
    check_eq("rst.bus_err", 32'(ifc.bus_err), 32'd0);
    reset = 1'b1;
    #1 check_eq("rst.release", 32'(ctrl_vec()), 32'(M_IMREQ));

    run_rtype("add", FN_ADD, ULA_ADD);
    run_rtype("sub", FN_SUB, ULA_SUB);
    run_rtype("and", FN_AND, ULA_AND);
    run_rtype("or",  FN_OR,  ULA_OR);
    run_rtype("slt", FN_SLT, ULA_SLT);

    fetch_decode("addi", OP_ADDI, 6'h15, 1'b0);
    #1 check_eq("addi.exec", 32'(ctrl_vec()), 32'(M_SRCB | ula_f(ULA_ADD)));
    tick();
    #1 check_eq("addi.wb", 32'(ctrl_vec()), 32'(M_RW | M_SRCB | ula_f(ULA_ADD)));
    tick();
    exp_cnt++;
    check_retired("addi");

    // lw with three wait states: dmem_read held for four MEM cycles, eight cycles total
    fetch_decode("lw", OP_LW, 6'h00, 1'b0);
    #1 check_eq("lw.exec", 32'(ctrl_vec()), 32'(M_SRCB | ula_f(ULA_ADD)));
    tick();
    for (int i = 0; i < 3; i++) begin
      ifc.dmem_ready = 1'b0;
      #1 check_eq("lw.mem_wait", 32'(ctrl_vec()), 32'(M_DRD | M_SRCB | ula_f(ULA_ADD)));
      tick();
    end
    ifc.dmem_ready = 1'b1;
    #1 check_eq("lw.mem_ready", 32'(ctrl_vec()), 32'(M_DRD | M_SRCB | ula_f(ULA_ADD)));
    tick();
    ifc.dmem_ready = 1'b0;
    #1 check_eq("lw.wb", 32'(ctrl_vec()), 32'(M_RW | M_M2R | M_SRCB | ula_f(ULA_ADD)));
    tick();
    exp_cnt++;
    check_retired("lw");

    fetch_decode("sw", OP_SW, 6'h00, 1'b0);
    #1 check_eq("sw.exec", 32'(ctrl_vec()), 32'(M_SRCB | ula_f(ULA_ADD)));
    tick();
    ifc.dmem_ready = 1'b1;
    #1 check_eq("sw.mem", 32'(ctrl_vec()), 32'(M_DWR | M_SRCB | ula_f(ULA_ADD)));
    tick();
    ifc.dmem_ready = 1'b0;
    exp_cnt++;
    check_retired("sw");

    fetch_decode("beq_t", OP_BEQ, 6'h00, 1'b0);
    ifc.zero_flag = 1'b1;
    #1 check_eq("beq_t.exec", 32'(ctrl_vec()), 32'(M_PCW | M_SRC_BR | ula_f(ULA_SUB)));
    tick();
    exp_cnt++;
    check_retired("beq_t");

    fetch_decode("beq_n", OP_BEQ, 6'h00, 1'b0);
    ifc.zero_flag = 1'b0;
    #1 check_eq("beq_n.exec", 32'(ctrl_vec()), 32'(ula_f(ULA_SUB)));
    tick();
    exp_cnt++;
    check_retired("beq_n");

    fetch_decode("j", OP_J, 6'h00, 1'b0);
    #1 check_eq("j.exec", 32'(ctrl_vec()), 32'(M_PCW | M_SRC_J));
    tick();
    exp_cnt++;
    check_retired("j");

    // Illegal decodes return straight to FETCH without retiring
    fetch_decode("ill_op", 6'h3F, 6'h20, 1'b1);
    check_retired("ill_op");
    fetch_decode("ill_fn", OP_RTYPE, 6'h00, 1'b1);
    check_retired("ill_fn");

    // Reset asserted for two clocks while lw is stalled in MEM
    fetch_decode("lw_rst", OP_LW, 6'h00, 1'b0);
    tick();
    ifc.dmem_ready = 1'b0;
    #1 check_eq("lw_rst.mem", 32'(ctrl_vec()), 32'(M_DRD | M_SRCB | ula_f(ULA_ADD)));
    tick();
    reset = 1'b0;
    tick(); tick();
    #1 check_eq("rst_mem.ctrl", 32'(ctrl_vec()), 32'd0);
    exp_cnt = 0;
    check_eq("rst_mem.count", ifc.instr_count, 32'(exp_cnt));
    check_eq("rst_mem.bus_err", 32'(ifc.bus_err), 32'd0);

    // imem_ready held low: 15 waiting FETCH cycles, then HALT with bus_err
    reset = 1'b1;
    ifc.imem_ready = 1'b0;
    for (int i = 0; i < 15; i++) begin
      #1 check_eq("to.fetch_wait", 32'(ctrl_vec()), 32'(M_IMREQ));
      tick();
    end
    #1 check_eq("to.halt_ctrl", 32'(ctrl_vec()), 32'd0);
    check_eq("to.bus_err", 32'(ifc.bus_err), 32'd1);
    ifc.imem_ready = 1'b1; ifc.dmem_ready = 1'b1;
    tick(); tick(); tick();
    #1 check_eq("halt.hold_ctrl", 32'(ctrl_vec()), 32'd0);
    check_eq("halt.hold_err", 32'(ifc.bus_err), 32'd1);
    check_eq("halt.count", ifc.instr_count, 32'd0);
    reset = 1'b0;
    tick();
    #1 check_eq("halt.rst_err", 32'(ifc.bus_err), 32'd0);
    reset = 1'b1;
    ifc.dmem_ready = 1'b0;
    #1 check_eq("halt.rst_fetch", 32'(ctrl_vec()), 32'(M_FETCH));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
